// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, header field layout and injector states.
package noc_pkg;

  localparam int FLIT_W   = 17;
  localparam int ID_W     = 4;
  localparam int LEN_W    = 3;
  localparam int CREDIT_W = 3;

  localparam int VALID_BIT = 16;
  localparam int DEST_LSB  = 12;
  localparam int SRC_LSB   = 8;
  localparam int LEN_LSB   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } inj_state_t;

  function automatic logic [FLIT_W-1:0] make_header(input logic [ID_W-1:0]  dest,
                                                    input logic [ID_W-1:0]  src,
                                                    input logic [LEN_W-1:0] len);
    logic [FLIT_W-1:0] h;
    h                     = '0;
    h[VALID_BIT]          = 1'b1;
    h[DEST_LSB +: ID_W]   = dest;
    h[SRC_LSB +: ID_W]    = src;
    h[LEN_LSB +: LEN_W]   = len;
    return h;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit tracker for one downstream buffer: starts full, saturates at BUF_DEPTH
// and flags a sticky error on a return that would overflow it.
module credit_counter
  import noc_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec,
  input  logic                inc,
  output logic [CREDIT_W-1:0] count,
  output logic                avail,
  output logic                err
);

  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(BUF_DEPTH);

  logic dec_ok;

  assign avail  = (count != '0);
  // A decrement at zero credit is ignored so a misbehaving user cannot wrap the count.
  assign dec_ok = dec & avail;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= FULL;
      err   <= 1'b0;
    end else if (dec_ok && !inc) begin
      count <= count - 1'b1;
    end else if (inc && !dec_ok) begin
      if (count == FULL) err <= 1'b1;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/local_packet_injector.sv
// Local-port packet injector: request + payload stream in, header/body flits out,
// every flit gated by a credit for the router's local input buffer.
//
// state | meaning
// IDLE  | waiting for a packet request, no flit driven
// HEAD  | request latched, header goes out once a credit is available
// BODY  | forwarding payload words until the latched length is exhausted
module local_packet_injector
  import noc_pkg::*;
#(
  parameter logic [ID_W-1:0] ROUTER_ID = '0,
  parameter int              BUF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  input  logic [ID_W-1:0]     req_dest_i,
  input  logic [LEN_W-1:0]    req_len_i,
  output logic                req_ready_o,
  input  logic                pay_valid_i,
  input  logic [15:0]         pay_data_i,
  output logic                pay_ready_o,
  input  logic                credit_inc_i,
  output logic [FLIT_W-1:0]   flit_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o,
  output logic                pkt_done_o,
  output logic                credit_err_o
);

  inj_state_t       state_q, state_d;
  logic [ID_W-1:0]  dest_q, dest_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic             done_q, done_d;
  logic             send;
  logic             avail;
  logic             pay_xfer;

  credit_counter #(.BUF_DEPTH(BUF_DEPTH)) u_credit (
    .clk   (clk),
    .rst   (rst),
    .dec   (send),
    .inc   (credit_inc_i),
    .count (credit_o),
    .avail (avail),
    .err   (credit_err_o)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      flit_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      flit_q  <= flit_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    len_d       = len_q;
    rem_d       = rem_q;
    flit_d      = '0;
    done_d      = 1'b0;
    send        = 1'b0;
    req_ready_o = 1'b0;
    pay_xfer    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          dest_d  = req_dest_i;
          len_d   = req_len_i;
          state_d = HEAD;
        end
      end
      HEAD: begin
        if (avail) begin
          send   = 1'b1;
          flit_d = make_header(dest_q, ROUTER_ID, len_q);
          if (len_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rem_d   = len_q;
            state_d = BODY;
          end
        end
      end
      BODY: begin
        pay_xfer = pay_valid_i & avail;
        if (pay_xfer) begin
          send   = 1'b1;
          flit_d = {1'b1, pay_data_i};
          rem_d  = rem_q - 1'b1;
          // Last body word: done pulse travels with the flit, then one idle gap.
          if (rem_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pay_ready_o = pay_xfer;
  assign flit_o      = flit_q;
  assign pkt_done_o  = done_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_local_packet_injector.sv
// Scoreboard bench for local_packet_injector: driver queues expected flits per
// packet, monitor checks flits and a counting credit model every cycle.
module tb_local_packet_injector;

  localparam logic [3:0] RID   = 4'd3;
  localparam int         DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [3:0]  req_dest_i;
  logic [2:0]  req_len_i;
  logic        req_ready_o;
  logic        pay_valid_i;
  logic [15:0] pay_data_i;
  logic        pay_ready_o;
  logic        credit_inc_i;
  logic [16:0] flit_o;
  logic [2:0]  credit_o;
  logic        busy_o;
  logic        pkt_done_o;
  logic        credit_err_o;

  local_packet_injector #(.ROUTER_ID(RID), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_dest_i(req_dest_i), .req_len_i(req_len_i),
    .req_ready_o(req_ready_o),
    .pay_valid_i(pay_valid_i), .pay_data_i(pay_data_i), .pay_ready_o(pay_ready_o),
    .credit_inc_i(credit_inc_i),
    .flit_o(flit_o), .credit_o(credit_o), .busy_o(busy_o),
    .pkt_done_o(pkt_done_o), .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] flit;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_credit = DEPTH;
  bit   m_err = 1'b0;
  int   outstanding = 0;
  int   flits_seen = 0;
  bit   router_en = 1'b0;
  bit   inc_req = 1'b0;

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Router side: returns one credit per flit it has received, at random times.
  always @(negedge clk) begin
    if (inc_req) begin
      credit_inc_i = 1'b1;
      inc_req      = 1'b0;
      if (outstanding > 0) outstanding--;
    end else if (router_en && outstanding > 0 && $urandom_range(0, 1) == 1) begin
      credit_inc_i = 1'b1;
      outstanding--;
    end else begin
      credit_inc_i = 1'b0;
    end
  end

  // Monitor: reference credit = depth - flits sent + credits returned, saturating.
  always @(posedge clk) begin
    logic sent;
    exp_t e;
    #1;
    if (!rst) begin
      exp_q.delete();
      m_credit    = DEPTH;
      m_err       = 1'b0;
      outstanding = 0;
      chk("rst_flit", flit_o, 17'h0);
      chk("rst_credit", 17'(credit_o), 17'(DEPTH));
      chk("rst_busy", 17'(busy_o), 17'h0);
      chk("rst_done", 17'(pkt_done_o), 17'h0);
      chk("rst_err", 17'(credit_err_o), 17'h0);
      chk("rst_req_ready", 17'(req_ready_o), 17'h1);
    end else begin
      sent = flit_o[16];
      if (sent) begin
        flits_seen++;
        outstanding++;
        if (m_credit == 0) timeout_fail("send_at_zero_credit");
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", flit_o, 17'h0);
        end else begin
          e = exp_q.pop_front();
          chk("flit", flit_o, e.flit);
          chk("pkt_done", 17'(pkt_done_o), 17'(e.done));
        end
      end else begin
        chk("idle_flit", flit_o, 17'h0);
        chk("idle_done", 17'(pkt_done_o), 17'h0);
      end
      if (sent && !credit_inc_i) begin
        if (m_credit > 0) m_credit--;
      end else if (!sent && credit_inc_i) begin
        if (m_credit == DEPTH) m_err = 1'b1;
        else m_credit++;
      end
      chk("credit", 17'(credit_o), 17'(m_credit));
      chk("credit_err", 17'(credit_err_o), 17'(m_err));
    end
  end

  task automatic send_pkt(input logic [3:0] dest, input logic [2:0] len,
                          input int bubble_at, input bit rnd, input int abort_after);
    logic [15:0] words[$];
    exp_t        e;
    int          idx, guard, bub;
    for (int i = 0; i < int'(len); i++) words.push_back(16'($urandom));
    @(negedge clk);
    req_valid_i = 1'b1;
    req_dest_i  = dest;
    req_len_i   = len;
    guard = 0;
    #1;
    while (!req_ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
      #1;
    end
    if (guard >= 200) timeout_fail("req_accept");
    e.flit = 17'h10000 | (17'(dest) << 12) | (17'(RID) << 8) | (17'(len) << 5);
    e.done = (len == 0);
    exp_q.push_back(e);
    for (int i = 0; i < int'(len); i++) begin
      e.flit = {1'b1, words[i]};
      e.done = (i == int'(len) - 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    idx = 0; guard = 0; bub = 2;
    while (idx < int'(len) && guard < 500) begin
      if (bubble_at == idx && bub > 0) begin
        pay_valid_i = 1'b0;
        bub--;
      end else begin
        pay_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      pay_data_i = words[idx];
      #1;
      if (pay_valid_i && pay_ready_o) idx++;
      @(negedge clk);
      guard++;
      if (abort_after >= 0 && idx == abort_after) break;
    end
    if (guard >= 500) timeout_fail("payload_drain");
    pay_valid_i = 1'b0;
  endtask

  task automatic settle();
    int guard;
    router_en = 1'b1;
    guard = 0;
    while ((outstanding > 0 || exp_q.size() > 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) timeout_fail("settle");
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 17'(exp_q.size()), 17'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int base;
    rst = 1'b0;
    req_valid_i = 1'b0; req_dest_i = '0; req_len_i = '0;
    pay_valid_i = 1'b0; pay_data_i = '0;
    credit_inc_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Fixed packet with no credit returns: credit walks 4 -> 1.
    router_en = 1'b0;
    send_pkt(4'd5, 3'd2, -1, 1'b0, -1);
    repeat (4) @(negedge clk);
    chk("credit_after_3_flits", 17'(credit_o), 17'(DEPTH - 3));
    chk("busy_after_pkt", 17'(busy_o), 17'h0);
    settle();

    // Header-only packet.
    send_pkt(4'd9, 3'd0, -1, 1'b0, -1);
    settle();

    // Credit starvation: len=7 with 4 credits stalls after header + 3 bodies.
    router_en = 1'b0;
    base = flits_seen;
    fork
      send_pkt(4'd2, 3'd7, -1, 1'b0, -1);
      begin
        int g;
        g = 0;
        while (flits_seen < base + DEPTH && g < 100) begin
          @(negedge clk);
          g++;
        end
        if (g >= 100) timeout_fail("stall_reach");
        @(negedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("stall_credit", 17'(credit_o), 17'h0);
          chk("stall_pay_ready", 17'(pay_ready_o), 17'h0);
          chk("stall_flit", flit_o, 17'h0);
        end
        inc_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("one_flit_per_credit", 17'(flits_seen - base), 17'(DEPTH + 1));
        router_en = 1'b1;
      end
    join
    settle();

    // Two-cycle payload bubble mid-packet.
    base = flits_seen;
    send_pkt(4'd7, 3'd5, 2, 1'b0, -1);
    settle();
    chk("bubble_flit_count", 17'(flits_seen - base), 17'd6);

    // Overflowing credit return while idle and full.
    router_en = 1'b0;
    inc_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_sticky", 17'(credit_err_o), 17'h1);
    chk("credit_saturated", 17'(credit_o), 17'(DEPTH));
    pulse_reset();
    @(negedge clk);
    chk("err_cleared", 17'(credit_err_o), 17'h0);

    // Reset in the middle of a body stream, then a clean packet.
    router_en = 1'b1;
    send_pkt(4'd11, 3'd5, -1, 1'b0, 2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_abort_flit", flit_o, 17'h0);
    send_pkt(4'd12, 3'd1, -1, 1'b0, -1);
    settle();

    // Randomized packets with random bubbles and random credit returns.
    router_en = 1'b1;
    for (int n = 0; n < 30; n++)
      send_pkt(4'($urandom), 3'($urandom), -1, 1'b1, -1);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
